// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg
//   Shared types and constants for the scan_decoder block.
//   dec_state_t : controller state (IDLE / DIRECT / SCAN)
//   MODE_*      : encodings of the mode input
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // True for every state that drives a strobe.
  function automatic logic state_active(input dec_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if
//   Control and strobe bundle between a controller and scan_decoder.
//   enable, mode, sel, scan_last, dwell : controller -> decoder
//   y, idx, wrap, busy                  : decoder -> controller
//   master : controller side, slave : decoder side
interface scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               enable;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   scan_last;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;
  logic               busy;

  modport master (
    output enable, mode, sel, scan_last, dwell,
    input  y, idx, wrap, busy
  );

  modport slave (
    input  enable, mode, sel, scan_last, dwell,
    output y, idx, wrap, busy
  );

endinterface

// File: rtl/scan_decoder_onehot_decode.sv
// onehot_decode
//   Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
//   sel : index to decode
//   en  : 0 forces all outputs low
//   y   : one-hot result, or all zeros when en = 0
module onehot_decode #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  output logic [(1<<SEL_W)-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder
//   Registered one-hot strobe decoder with a direct mode and a built-in
//   scan sequencer that walks indices 0..scan_last, holding each for
//   dwell+1 cycles.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, highest priority
//   bus   : scan_decoder_if slave (enable/mode/sel/scan_last/dwell in,
//           y/idx/wrap/busy out, all outputs registered)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | enable low; y = 0, idx = 0, cnt = 0, busy = 0
//   DIRECT | y = 1 << sel, idx = sel; cnt held at 0
//   SCAN   | sequencer walks idx 0..scan_last, dwell+1 cycles per index
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_decoder_if.slave  bus
);

  localparam int OUT_W = 1 << SEL_W;

  dec_state_t         state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    idx_d   = '0;
    cnt_d   = '0;
    wrap_d  = 1'b0;

    if (bus.enable) begin
      state_d = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
    end

    unique case (state_d)
      DIRECT: begin
        idx_d = bus.sel;
      end
      SCAN: begin
        // Entry counts as the first cycle of index 0, so no wrap here.
        if (state_q != SCAN) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q < bus.dwell) begin
          idx_d = idx_q;
          cnt_d = cnt_q + 1'b1;
        end else begin
          // >= rather than == so a scan_last lowered below idx still wraps.
          cnt_d = '0;
          if (idx_q >= bus.scan_last) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d = '0;
        cnt_d = '0;
      end
    endcase

    busy_d = state_active(state_d);
  end

  // Decode the next index so y lands in the same register stage as idx.
  onehot_decode #(
    .SEL_W (SEL_W)
  ) u_decode (
    .sel (idx_d),
    .en  (busy_d),
    .y   (y_d)
  );

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder
//   Directed bench for scan_decoder at SEL_W = 3 (main), 1 and 4.
module tb_scan_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  scan_decoder_if #(.SEL_W(3), .DWELL_W(8)) bus3 ();
  scan_decoder_if #(.SEL_W(1), .DWELL_W(8)) bus1 ();
  scan_decoder_if #(.SEL_W(4), .DWELL_W(8)) bus4 ();

  scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  scan_decoder #(.SEL_W(1), .DWELL_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus3.enable = 1'b1; bus3.mode = 1'b0; bus3.sel = 3'd3;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++; if (bus3.y !== 8'h00) $display("FAIL reset_y: got %h want 00", bus3.y); else n_pass++;
      n_checks++; if (bus3.idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", bus3.idx); else n_pass++;
      n_checks++; if (bus3.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus3.busy); else n_pass++;
      n_checks++; if (bus3.wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", bus3.wrap); else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [7:0] e_y;
    bus3.enable = 1'b1; bus3.mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      bus3.sel = 3'(s);
      e_y = 8'h01 << s;
      step();
      n_checks++; if (bus3.y !== e_y) $display("FAIL direct_y sel=%0d: got %h want %h", s, bus3.y, e_y); else n_pass++;
      n_checks++; if (bus3.idx !== 3'(s)) $display("FAIL direct_idx: got %0d want %0d", bus3.idx, s); else n_pass++;
      n_checks++; if (bus3.busy !== 1'b1) $display("FAIL direct_busy: got %b want 1", bus3.busy); else n_pass++;
    end
  endtask

  task automatic test_enable_gating();
    bus3.mode = 1'b0; bus3.sel = 3'd5; bus3.enable = 1'b1;
    step();
    n_checks++; if (bus3.y !== 8'h20) $display("FAIL gate_pre_y: got %h want 20", bus3.y); else n_pass++;
    bus3.enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (bus3.y !== 8'h00) $display("FAIL gate_off_y: got %h want 00", bus3.y); else n_pass++;
      n_checks++; if (bus3.busy !== 1'b0) $display("FAIL gate_off_busy: got %b want 0", bus3.busy); else n_pass++;
      n_checks++; if (bus3.idx !== 3'd0) $display("FAIL gate_off_idx: got %0d want 0", bus3.idx); else n_pass++;
    end
    bus3.enable = 1'b1;
    step();
    n_checks++; if (bus3.y !== 8'h20) $display("FAIL gate_on_y: got %h want 20", bus3.y); else n_pass++;
    n_checks++; if (bus3.busy !== 1'b1) $display("FAIL gate_on_busy: got %b want 1", bus3.busy); else n_pass++;
  endtask

  task automatic test_scan_full();
    int e_idx;
    logic e_wrap;
    logic [7:0] e_y;
    bus3.enable = 1'b1; bus3.mode = 1'b1; bus3.dwell = 8'd2; bus3.scan_last = 3'd7;
    for (int k = 0; k < 50; k++) begin
      e_idx  = (k / 3) % 8;
      e_wrap = (k > 0) && (k % 24 == 0);
      e_y    = 8'h01 << e_idx;
      step();
      n_checks++; if (bus3.y !== e_y) $display("FAIL scan_full_y k=%0d: got %h want %h", k, bus3.y, e_y); else n_pass++;
      n_checks++; if (bus3.idx !== 3'(e_idx)) $display("FAIL scan_full_idx k=%0d: got %0d want %0d", k, bus3.idx, e_idx); else n_pass++;
      n_checks++; if (bus3.wrap !== e_wrap) $display("FAIL scan_full_wrap k=%0d: got %b want %b", k, bus3.wrap, e_wrap); else n_pass++;
      n_checks++; if (bus3.busy !== 1'b1) $display("FAIL scan_full_busy k=%0d: got %b want 1", k, bus3.busy); else n_pass++;
    end
  endtask

  task automatic test_scan_partial();
    int e_idx;
    logic e_wrap;
    bus3.mode = 1'b0; bus3.sel = 3'd1;
    step();
    n_checks++; if (bus3.y !== 8'h02) $display("FAIL partial_direct_y: got %h want 02", bus3.y); else n_pass++;
    bus3.mode = 1'b1; bus3.dwell = 8'd0; bus3.scan_last = 3'd2;
    for (int k = 0; k < 6; k++) begin
      e_idx  = k % 3;
      e_wrap = (k > 0) && (k % 3 == 0);
      step();
      n_checks++; if (bus3.idx !== 3'(e_idx)) $display("FAIL partial_idx k=%0d: got %0d want %0d", k, bus3.idx, e_idx); else n_pass++;
      n_checks++; if (bus3.wrap !== e_wrap) $display("FAIL partial_wrap k=%0d: got %b want %b", k, bus3.wrap, e_wrap); else n_pass++;
    end
    bus3.scan_last = 3'd0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (bus3.y !== 8'h01) $display("FAIL last0_y k=%0d: got %h want 01", k, bus3.y); else n_pass++;
      n_checks++; if (bus3.idx !== 3'd0) $display("FAIL last0_idx k=%0d: got %0d want 0", k, bus3.idx); else n_pass++;
      n_checks++; if (bus3.wrap !== 1'b1) $display("FAIL last0_wrap k=%0d: got %b want 1", k, bus3.wrap); else n_pass++;
    end
  endtask

  task automatic test_live_dwell_and_reset();
    int exp_seq [7] = '{1, 1, 2, 2, 3, 3, 4};
    bus3.mode = 1'b0; bus3.sel = 3'd6;
    step();
    n_checks++; if (bus3.y !== 8'h40) $display("FAIL switch_direct_y: got %h want 40", bus3.y); else n_pass++;
    n_checks++; if (bus3.idx !== 3'd6) $display("FAIL switch_direct_idx: got %0d want 6", bus3.idx); else n_pass++;
    bus3.mode = 1'b1; bus3.dwell = 8'd10; bus3.scan_last = 3'd7;
    step();
    n_checks++; if (bus3.y !== 8'h01) $display("FAIL restart_y: got %h want 01", bus3.y); else n_pass++;
    n_checks++; if (bus3.wrap !== 1'b0) $display("FAIL restart_wrap: got %b want 0", bus3.wrap); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (bus3.idx !== 3'd0) $display("FAIL dwell10_idx k=%0d: got %0d want 0", k, bus3.idx); else n_pass++;
    end
    bus3.dwell = 8'd1;
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++; if (bus3.idx !== 3'(exp_seq[k])) $display("FAIL dwell_live_idx k=%0d: got %0d want %0d", k, bus3.idx, exp_seq[k]); else n_pass++;
    end
    rst_n = 1'b0;
    step();
    n_checks++; if (bus3.y !== 8'h00) $display("FAIL midrst_y: got %h want 00", bus3.y); else n_pass++;
    n_checks++; if (bus3.idx !== 3'd0) $display("FAIL midrst_idx: got %0d want 0", bus3.idx); else n_pass++;
    n_checks++; if (bus3.wrap !== 1'b0) $display("FAIL midrst_wrap: got %b want 0", bus3.wrap); else n_pass++;
    n_checks++; if (bus3.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus3.busy); else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++; if (bus3.y !== 8'h01) $display("FAIL postrst_y: got %h want 01", bus3.y); else n_pass++;
    n_checks++; if (bus3.wrap !== 1'b0) $display("FAIL postrst_wrap: got %b want 0", bus3.wrap); else n_pass++;
    n_checks++; if (bus3.busy !== 1'b1) $display("FAIL postrst_busy: got %b want 1", bus3.busy); else n_pass++;
    step();
    step();
    n_checks++; if (bus3.idx !== 3'd1) $display("FAIL postrst_adv_idx: got %0d want 1", bus3.idx); else n_pass++;
    bus3.enable = 1'b0;
    step();
  endtask

  task automatic test_sel1();
    int e_idx;
    logic e_wrap;
    logic [1:0] e_y;
    bus1.enable = 1'b1; bus1.mode = 1'b0;
    for (int s = 0; s < 2; s++) begin
      bus1.sel = 1'(s);
      e_y = 2'b01 << s;
      step();
      n_checks++; if (bus1.y !== e_y) $display("FAIL w1_direct_y: got %b want %b", bus1.y, e_y); else n_pass++;
      n_checks++; if (bus1.idx !== 1'(s)) $display("FAIL w1_direct_idx: got %0d want %0d", bus1.idx, s); else n_pass++;
    end
    bus1.mode = 1'b1; bus1.dwell = 8'd2; bus1.scan_last = 1'b1;
    for (int k = 0; k < 14; k++) begin
      e_idx  = (k / 3) % 2;
      e_wrap = (k > 0) && (k % 6 == 0);
      e_y    = 2'b01 << e_idx;
      step();
      n_checks++; if (bus1.y !== e_y) $display("FAIL w1_scan_y k=%0d: got %b want %b", k, bus1.y, e_y); else n_pass++;
      n_checks++; if (bus1.wrap !== e_wrap) $display("FAIL w1_scan_wrap k=%0d: got %b want %b", k, bus1.wrap, e_wrap); else n_pass++;
      n_checks++; if (!$onehot(bus1.y) || bus1.y !== (2'b01 << bus1.idx)) $display("FAIL w1_invariant k=%0d: y %b idx %0d", k, bus1.y, bus1.idx); else n_pass++;
    end
    bus1.enable = 1'b0;
    step();
    n_checks++; if (bus1.y !== 2'b00) $display("FAIL w1_off_y: got %b want 00", bus1.y); else n_pass++;
  endtask

  task automatic test_sel4();
    int e_idx;
    logic e_wrap;
    logic [15:0] e_y;
    bus4.enable = 1'b1; bus4.mode = 1'b0;
    for (int s = 0; s < 16; s++) begin
      bus4.sel = 4'(s);
      e_y = 16'h0001 << s;
      step();
      n_checks++; if (bus4.y !== e_y) $display("FAIL w4_direct_y: got %h want %h", bus4.y, e_y); else n_pass++;
      n_checks++; if (bus4.idx !== 4'(s)) $display("FAIL w4_direct_idx: got %0d want %0d", bus4.idx, s); else n_pass++;
    end
    bus4.mode = 1'b1; bus4.dwell = 8'd2; bus4.scan_last = 4'd15;
    for (int k = 0; k < 52; k++) begin
      e_idx  = (k / 3) % 16;
      e_wrap = (k > 0) && (k % 48 == 0);
      e_y    = 16'h0001 << e_idx;
      step();
      n_checks++; if (bus4.y !== e_y) $display("FAIL w4_scan_y k=%0d: got %h want %h", k, bus4.y, e_y); else n_pass++;
      n_checks++; if (bus4.wrap !== e_wrap) $display("FAIL w4_scan_wrap k=%0d: got %b want %b", k, bus4.wrap, e_wrap); else n_pass++;
      n_checks++; if (!$onehot(bus4.y) || bus4.y !== (16'h0001 << bus4.idx)) $display("FAIL w4_invariant k=%0d: y %h idx %0d", k, bus4.y, bus4.idx); else n_pass++;
    end
    bus4.enable = 1'b0;
    step();
    n_checks++; if (bus4.busy !== 1'b0) $display("FAIL w4_off_busy: got %b want 0", bus4.busy); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus3.enable = 1'b0; bus3.mode = 1'b0; bus3.sel = '0; bus3.scan_last = '0; bus3.dwell = '0;
    bus1.enable = 1'b0; bus1.mode = 1'b0; bus1.sel = '0; bus1.scan_last = '0; bus1.dwell = '0;
    bus4.enable = 1'b0; bus4.mode = 1'b0; bus4.sel = '0; bus4.scan_last = '0; bus4.dwell = '0;
    test_reset();
    test_direct();
    test_enable_gating();
    test_scan_full();
    test_scan_partial();
    test_live_dwell_and_reset();
    test_sel1();
    test_sel4();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
